matrix_rand_fill_ctrl: RTL

//  Sequences the shared random_num_generator to fill a ROWS x COLS matrix buffer with values in [min,max].

---
 rtl/matrix_rand_pkg.sv | 23 ++
 rtl/mrand_index_counter.sv | 43 ++++
 rtl/matrix_rand_fill_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/matrix_rand_pkg.sv
// Shared types and defaults for the random matrix fill controller.
// State encoding, widths and watchdog limit.
package matrix_rand_pkg;

  localparam int DEF_DW       = 8;
  localparam int ADDR_W       = 6;
  localparam int DEF_MAX_ROWS = 8;
  localparam int DEF_MAX_COLS = 8;
  localparam int DEF_WARMUP   = 2;
  localparam int WD_LIMIT     = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WARM,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/mrand_index_counter.sv
// Row/column index counter for row-major matrix fill.
// Produces the linear write address and a last-element flag.
module mrand_index_counter
  import matrix_rand_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_adv,
  input  logic [3:0]        i_rows,
  input  logic [3:0]        i_cols,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [3:0] r_row;
  logic [3:0] r_col;
  logic       w_col_end;

  assign w_col_end = (r_col == i_cols - 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + 4'd1;
      end else begin
        r_col <= r_col + 4'd1;
      end
    end
  end

  assign o_addr = ADDR_W'(r_row) * ADDR_W'(i_cols)
                + ADDR_W'(r_col);
  assign o_last = w_col_end && (r_row == i_rows - 4'd1);

endmodule

// File: rtl/matrix_rand_fill_ctrl.sv
// Sequences the random generator to fill a ROWS x COLS matrix
// row-major, discarding warm-up samples and honouring wr_ready.
module matrix_rand_fill_ctrl
  import matrix_rand_pkg::*;
#(
  parameter int MAX_ROWS = DEF_MAX_ROWS,
  parameter int MAX_COLS = DEF_MAX_COLS,
  parameter int WARMUP   = DEF_WARMUP,
  parameter int DW       = DEF_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        rows_cfg,
  input  logic [3:0]        cols_cfg,
  input  logic [DW-1:0]     min_cfg,
  input  logic [DW-1:0]     max_cfg,
  output logic              rng_gen_en,
  output logic [DW-1:0]     rng_min,
  output logic [DW-1:0]     rng_max,
  input  logic [DW-1:0]     rng_data,
  input  logic              rng_valid,
  input  logic              rng_range_err,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t        r_state;
  state_t        r_next;
  logic [3:0]    r_rows;
  logic [3:0]    r_cols;
  logic [DW-1:0] r_min;
  logic [DW-1:0] r_max;
  logic [DW-1:0] r_data;
  logic          r_error;
  logic [3:0]    r_warm_cnt;
  logic          r_warm_wait;
  logic [2:0]    r_wd;

  logic w_start_acc;
  logic w_cfg_bad;
  logic w_warm_last;
  logic w_waiting;
  logic w_wd_exp;
  logic w_adv;
  logic w_last;

  assign w_start_acc = (r_state == S_IDLE) && start && !abort;
  assign w_cfg_bad   = (r_rows == 4'd0) || (r_cols == 4'd0)
                    || (r_rows > 4'(MAX_ROWS))
                    || (r_cols > 4'(MAX_COLS))
                    || (r_max < r_min);
  assign w_warm_last = (r_warm_cnt == 4'(WARMUP - 1));
  assign w_waiting   = (r_state == S_WAIT)
                    || ((r_state == S_WARM) && r_warm_wait);
  assign w_wd_exp    = (r_wd == 3'(WD_LIMIT - 1)) && !rng_valid;
  assign w_adv       = (r_state == S_WRITE) && wr_ready && !abort;

  mrand_index_counter u_idx (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start_acc),
    .i_adv  (w_adv),
    .i_rows (r_rows),
    .i_cols (r_cols),
    .o_addr (wr_addr),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    if (abort) begin
      r_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (start) r_next = S_CHECK;
        S_CHECK: r_next = w_cfg_bad ? S_ERR : S_WARM;
        S_WARM: begin
          if (r_warm_wait) begin
            if (rng_valid) begin
              if (w_warm_last) r_next = S_REQ;
            end else if (w_wd_exp) begin
              r_next = S_ERR;
            end
          end
        end
        S_REQ:   r_next = S_WAIT;
        S_WAIT: begin
          if (rng_valid)
            r_next = rng_range_err ? S_ERR : S_WRITE;
          else if (w_wd_exp)
            r_next = S_ERR;
        end
        S_WRITE: if (wr_ready) r_next = w_last ? S_DONE : S_REQ;
        S_DONE:  r_next = S_IDLE;
        S_ERR:   r_next = S_IDLE;
        default: r_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows      <= '0;
      r_cols      <= '0;
      r_min       <= '0;
      r_max       <= '0;
      r_data      <= '0;
      r_error     <= 1'b0;
      r_warm_cnt  <= '0;
      r_warm_wait <= 1'b0;
      r_wd        <= '0;
    end else begin
      r_wd <= (w_waiting && !rng_valid) ? r_wd + 3'd1 : 3'd0;
      if (r_next == S_ERR) r_error <= 1'b1;
      if (w_start_acc) begin
        r_rows      <= rows_cfg;
        r_cols      <= cols_cfg;
        r_min       <= min_cfg;
        r_max       <= max_cfg;
        r_error     <= 1'b0;
        r_warm_cnt  <= '0;
        r_warm_wait <= 1'b0;
      end else if ((r_state == S_WARM) && !abort) begin
        // alternate pulse / wait so only one warm sample is in flight
        if (!r_warm_wait) begin
          r_warm_wait <= 1'b1;
        end else if (rng_valid) begin
          r_warm_wait <= 1'b0;
          r_warm_cnt  <= r_warm_cnt + 4'd1;
        end
      end
      if ((r_state == S_WAIT) && rng_valid && !abort
          && !rng_range_err)
        r_data <= rng_data;
    end
  end

  assign rng_gen_en = (r_state == S_REQ)
                   || ((r_state == S_WARM) && !r_warm_wait);
  assign rng_min    = r_min;
  assign rng_max    = r_max;
  assign wr_en      = (r_state == S_WRITE);
  assign wr_data    = r_data;
  assign busy       = (r_state != S_IDLE) && (r_state != S_ERR);
  assign done       = (r_state == S_DONE);
  assign error      = r_error;

endmodule
